// File: rtl/mux8_arb_pkg.sv
// Shared constants, state encoding and the round-robin search helper
// for the 8-way arbitrated mux.
package mux8_arb_pkg;

    localparam int NUM_REQ      = 8;
    localparam int SEL_W        = 3;
    localparam int CNT_W        = 4;
    localparam int DEF_MAX_HOLD = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Offsets 1..8 from base; walking downward lets the nearest hit win,
    // and offset 8 (base itself) is only chosen when nothing else requests.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req_v,
                                      input logic [SEL_W-1:0]   base);
        pick_t            p;
        logic [SEL_W-1:0] idx;
        p.found = 1'b0;
        p.idx   = {SEL_W{1'b0}};
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = base + SEL_W'(i);
            p   = req_v[idx] ? pick_t'{found: 1'b1, idx: idx} : p;
        end
        return p;
    endfunction

endpackage

// File: rtl/mux8.sv
// Plain 8:1 single-bit multiplexer.
module mux8
    import mux8_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_din,
    input  logic [SEL_W-1:0]   i_sel,
    output logic               o_y
);

    // Select one data bit by index
    always_comb begin
        o_y = 1'b0;
        case (i_sel)
            3'd0:    o_y = i_din[0];
            3'd1:    o_y = i_din[1];
            3'd2:    o_y = i_din[2];
            3'd3:    o_y = i_din[3];
            3'd4:    o_y = i_din[4];
            3'd5:    o_y = i_din[5];
            3'd6:    o_y = i_din[6];
            3'd7:    o_y = i_din[7];
            default: o_y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter over 8 requesters with bounded hold time; the
// owner's data bit is steered out through mux8.
module mux8_arbiter
    import mux8_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] din,
    input  logic               done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               busy,
    output logic               y
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [SEL_W-1:0]   r_sel,   w_sel_nxt;
    logic [SEL_W-1:0]   r_last,  w_last_nxt;
    logic [CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               r_busy,  w_busy_nxt;

    pick_t              w_pick;
    logic               w_others;
    logic               w_timeout;
    logic               w_release;
    logic               w_mux_y;

    // While granted r_last equals the owner, so one search serves both
    // the idle start and the handover.
    assign w_pick    = rr_pick(req, r_last);
    assign w_others  = |(req & ~r_gnt);
    assign w_timeout = (r_cnt == HOLD_LAST) && w_others;
    assign w_release = done | ~req[r_sel] | w_timeout;

    // Next-state and registered-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        case (r_state)
            IDLE: begin
                if (w_pick.found) begin
                    w_state_nxt = GRANT;
                    w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick.idx;
                    w_sel_nxt   = w_pick.idx;
                    w_last_nxt  = w_pick.idx;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_gnt_nxt  = {NUM_REQ{1'b0}};
                    w_sel_nxt  = {SEL_W{1'b0}};
                    w_busy_nxt = 1'b0;
                    w_cnt_nxt  = {CNT_W{1'b0}};
                end
            end
            GRANT: begin
                if (w_release && w_pick.found) begin
                    w_gnt_nxt  = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick.idx;
                    w_sel_nxt  = w_pick.idx;
                    w_last_nxt = w_pick.idx;
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = {CNT_W{1'b0}};
                end else if (w_release) begin
                    w_state_nxt = IDLE;
                    w_gnt_nxt   = {NUM_REQ{1'b0}};
                    w_sel_nxt   = {SEL_W{1'b0}};
                    w_busy_nxt  = 1'b0;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    // Sole requester at the hold limit keeps the grant; count restarts.
                    w_cnt_nxt = (r_cnt == HOLD_LAST) ? {CNT_W{1'b0}} : r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = {NUM_REQ{1'b0}};
                w_sel_nxt   = {SEL_W{1'b0}};
                w_busy_nxt  = 1'b0;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= {NUM_REQ{1'b0}};
            r_sel   <= {SEL_W{1'b0}};
            r_last  <= 3'd7;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    mux8 u_mux8 (
        .i_din (din),
        .i_sel (r_sel),
        .o_y   (w_mux_y)
    );

    assign gnt  = r_gnt;
    assign sel  = r_sel;
    assign busy = r_busy;
    assign y    = r_busy & w_mux_y;

endmodule

// File: tb/tb_mux8_arbiter.sv
// Vector-table bench for mux8_arbiter: expected grants are queued when
// inputs are driven and checked one cycle later on the falling edge.
module tb_mux8_arbiter;
    import mux8_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] din = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       do_rst;
        logic [7:0] req;
        logic [7:0] din;
        logic       done;
        logic [7:0] exp_gnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mux8_arbiter #(.MAX_HOLD(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .din  (din),
        .done (done),
        .gnt  (gnt),
        .sel  (sel),
        .busy (busy),
        .y    (y)
    );

    function automatic void add(input logic r, input logic [7:0] rq, input logic [7:0] d,
                                input logic dn, input logic [7:0] eg);
        vec_t v;
        v.do_rst = r; v.req = rq; v.din = d; v.done = dn; v.exp_gnt = eg;
        vecs.push_back(v);
    endfunction

    function automatic logic [2:0] idx_of(input logic [7:0] g);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (g[i]) r = 3'(i);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] eg);
        logic [2:0] es;
        logic       eb;
        logic       ey;
        es = idx_of(eg);
        eb = |eg;
        ey = eb ? din[es] : 1'b0;
        check({tag, ".gnt"},    {24'd0, gnt},  {24'd0, eg});
        check({tag, ".sel"},    {29'd0, sel},  {29'd0, es});
        check({tag, ".busy"},   {31'd0, busy}, {31'd0, eb});
        check({tag, ".y"},      {31'd0, y},    {31'd0, ey});
        check({tag, ".onehot"}, {31'd0, $onehot0(gnt)}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 8'h00; din = 8'h00; done = 1'b0;
        @(negedge clk);
        check_outputs("reset", 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] eg;

        // Idle hold, first grant latency, y tracking din, release on dropped req
        add(1'b1, 8'h00, 8'h00, 1'b0, 8'h00);
        add(1'b0, 8'h01, 8'h01, 1'b0, 8'h01);
        add(1'b0, 8'h01, 8'h00, 1'b0, 8'h01);
        add(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
        // All requesting with done every cycle: full rotation, no idle gaps
        for (int k = 0; k < 9; k++) add(k == 0, 8'hFF, 8'hAA, 1'b1, 8'(8'h01 << (k % 8)));
        // Two requesters, no done: hold limit forces alternation every 4 cycles
        for (int k = 0; k < 10; k++)
            add(k == 0, 8'h06, 8'h04, 1'b0, (k < 4) ? 8'h02 : ((k < 8) ? 8'h04 : 8'h02));
        // Sole requester never times out; drop req releases
        for (int k = 0; k < 20; k++) add(k == 0, 8'h08, 8'hFF, 1'b0, 8'h08);
        add(1'b0, 8'h00, 8'hFF, 1'b0, 8'h00);
        // done together with dropped req is one handover
        add(1'b1, 8'h90, 8'h10, 1'b0, 8'h10);
        add(1'b0, 8'h80, 8'h10, 1'b1, 8'h80);
        add(1'b0, 8'h80, 8'h80, 1'b0, 8'h80);
        // done from a sole requester re-grants it; with another pending it hands over
        add(1'b1, 8'h02, 8'h02, 1'b0, 8'h02);
        add(1'b0, 8'h02, 8'h02, 1'b1, 8'h02);
        add(1'b0, 8'h06, 8'h00, 1'b1, 8'h04);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_rst) do_reset();
            req  = vecs[i].req;
            din  = vecs[i].din;
            done = vecs[i].done;
            exp_q.push_back(vecs[i].exp_gnt);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL vec%0d: scoreboard empty", i);
            end else begin
                eg = exp_q.pop_front();
                check($sformatf("vec%0d", i), {24'd0, gnt}, {24'd0, eg});
                check_outputs($sformatf("vec%0d", i), eg);
            end
        end

        // Reset in the middle of a grant drops everything at once
        do_reset();
        req = 8'h20; din = 8'h20; done = 1'b0;
        @(negedge clk);
        check_outputs("pre_rst", 8'h20);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.gnt",  {24'd0, gnt},  32'd0);
        check("midrst.sel",  {29'd0, sel},  32'd0);
        check("midrst.busy", {31'd0, busy}, 32'd0);
        check("midrst.y",    {31'd0, y},    32'd0);
        @(negedge clk);
        rst = 1'b0; req = 8'h21; din = 8'h01;
        @(negedge clk);
        check_outputs("post_rst", 8'h01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux8_arbiter.md
MUX8_ARBITER -- requirements
Module: mux8_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 4, meaning the maximum number of consecutive cycles one requester holds the grant while another requester is waiting (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 8 bits: request vector; bit k is requester k, which owns mux data input k.
REQ-005 The block SHALL have port din, input, 8 bits: mux data inputs; bit k is data of requester k.
REQ-006 The block SHALL have port done, input, 1 bit: the current owner releases its grant.
REQ-007 The block SHALL have port gnt, output, 8 bits: one-hot grant, registered.
REQ-008 The block SHALL have port sel, output, 3 bits: mux select equal to the index of the set gnt bit, registered.
REQ-009 The block SHALL have port busy, output, 1 bit: a grant is active, registered.
REQ-010 The block SHALL have port y, output, 1 bit: selected data, equal to din[sel] when busy, else 0 (combinational from the registered sel).

Function
REQ-011 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner).
REQ-012 A 3-bit pointer last SHALL hold the most recent owner; arbitration SHALL search req starting at last+1 modulo 8 and pick the first set bit.
REQ-013 In IDLE with any req bit set, the FSM SHALL go to GRANT with gnt, sel and busy updated on the next edge, giving 1-cycle latency from req to gnt.
REQ-014 In IDLE with req == 0, the FSM SHALL hold all outputs at 0.
REQ-015 In GRANT, a hold counter SHALL count owner cycles starting at 0 on each new grant.
REQ-016 A release SHALL occur when done = 1, or when req[owner] = 0, or when the counter reaches MAX_HOLD-1 while another req bit is set; simultaneous causes SHALL count as one release.
REQ-017 On release with any other requester pending, the FSM SHALL hand over directly to the next round-robin winner on the next edge, with no idle cycle, and update last.
REQ-018 On release via done or a dropped req with no other requester pending, the FSM SHALL go to IDLE, and gnt, busy and sel SHALL clear on the next edge.
REQ-019 On timeout with only the owner requesting, the owner SHALL keep the grant and the counter SHALL restart at 0.
REQ-020 A releasing owner that still requests SHALL be re-granted only after the search wraps, so it regains the grant immediately only if it is the sole requester.
REQ-021 gnt SHALL be one-hot or zero at all times, and sel SHALL never change while busy is high except on a handover edge.

Reset
REQ-022 rst = 1 SHALL immediately force state = IDLE, gnt = 0, sel = 0, busy = 0, counter = 0, last = 7 (so the first search starts at requester 0), and y = 0.
REQ-023 Reset asserted mid-grant SHALL drop the grant with no handover, and after deassertion arbitration SHALL restart from requester 0.

Structure
REQ-024 A shared package mux8_arb_pkg SHALL hold NUM_REQ = 8, SEL_W = 3, the state enum {IDLE, GRANT}, and the default MAX_HOLD.
REQ-025 The existing 8:1 mux mux8 SHALL be instantiated as the single sub-module to produce y from din and sel, gated by busy.

Verification
REQ-026 Reset with req = 8'h00, then apply req = 8'h01 -> gnt = 8'h01, sel = 0 and busy = 1 one cycle later, and y follows din[0].
REQ-027 From reset, apply req = 8'hFF with done pulsed every cycle -> grants rotate 0,1,2,...,7,0 with no idle cycles.
REQ-028 Hold req = 8'h06 with done = 0 and MAX_HOLD = 4 -> requester 1 is granted for 4 cycles, then requester 2 for 4 cycles, then requester 1 again.
REQ-029 Hold req = 8'h08 alone for 20 cycles -> gnt stays 8'h08 throughout with no release; then drop req to 0 -> busy = 0 next cycle.
REQ-030 Grant requester 5 with din = 8'h20, then assert rst mid-grant -> gnt, sel, busy and y go to 0 immediately; release rst with req = 8'h21 -> requester 0 is granted first.
REQ-031 Pulse done in the same cycle that the owner drops req, with req = 8'h90 and owner 4 -> a single handover to requester 7 occurs, and gnt stays one-hot.
